// File: rtl/branch_redirect_pc.sv
// Fetch PC unit: sequential fetch, taken-branch redirect with timed flush, halt on misaligned target.
// Latency: one cycle from a resolved branch to the redirected pc, the flush and the ack pulse.
// Backpressure: stall holds pc and the flush countdown; a taken redirect overrides stall; HALT exits only on reset.
module branch_redirect_pc #(
    parameter int              PC_W         = 8,
    parameter logic [PC_W-1:0] RESET_PC     = '0,
    parameter int              PC_STEP      = 4,
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            br_valid,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    output logic [PC_W-1:0] pc,
    output logic            pc_valid,
    output logic            flush,
    output logic            redirect_ack,
    output logic            misalign_err,
    output logic            halted,
    output logic [15:0]     redirect_count
);

    typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;

    localparam logic [PC_W-1:0] STEP       = PC_W'(PC_STEP);
    localparam logic [2:0]      FLUSH_INIT = 3'(FLUSH_CYCLES);

    state_t     state;
    logic [2:0] flush_cnt;
    logic       take_redirect;
    logic       take_misalign;

    assign take_redirect = br_valid && br_taken && (br_target[1:0] == 2'b00);
    assign take_misalign = br_valid && br_taken && (br_target[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= RUN;
            flush_cnt      <= '0;
            pc             <= RESET_PC;
            pc_valid       <= 1'b0;
            flush          <= 1'b0;
            redirect_ack   <= 1'b0;
            misalign_err   <= 1'b0;
            halted         <= 1'b0;
            redirect_count <= '0;
        end else begin
            redirect_ack <= br_valid && (state != HALT);
            if (state != HALT) begin
                if (take_redirect) begin
                    pc        <= br_target;
                    pc_valid  <= 1'b1;
                    state     <= FLUSH;
                    flush_cnt <= FLUSH_INIT;
                    flush     <= 1'b1;
                    if (redirect_count != 16'hFFFF)
                        redirect_count <= redirect_count + 16'd1;
                end else if (take_misalign) begin
                    // pc is frozen at its last value for post-mortem inspection
                    state        <= HALT;
                    pc_valid     <= 1'b0;
                    flush        <= 1'b1;
                    halted       <= 1'b1;
                    misalign_err <= 1'b1;
                end else if (!pc_valid) begin
                    // first edge out of reset only qualifies pc; no advance yet
                    pc_valid <= 1'b1;
                end else if (!stall) begin
                    pc <= pc + STEP;
                    if (state == FLUSH) begin
                        if (flush_cnt <= 3'd1) begin
                            state     <= RUN;
                            flush_cnt <= '0;
                            flush     <= 1'b0;
                        end else begin
                            flush_cnt <= flush_cnt - 3'd1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_redirect_pc.sv
// Scenario bench for branch_redirect_pc: per-cycle expectations are queued with the stimulus
// and popped for comparison one cycle later, once the DUT has registered the result.
module tb_branch_redirect_pc;

    typedef struct packed {
        logic [7:0]  pc;
        logic        pc_valid;
        logic        flush;
        logic        ack;
        logic        err;
        logic        halted;
        logic [15:0] cnt;
    } exp_t;

    typedef struct packed {
        logic       rst;
        logic       stall;
        logic       bv;
        logic       bt;
        logic [7:0] tgt;
        exp_t       e;
    } stim_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        br_valid = 1'b0;
    logic        br_taken = 1'b0;
    logic [7:0]  br_target = 8'h00;
    logic [7:0]  pc;
    logic        pc_valid;
    logic        flush;
    logic        redirect_ack;
    logic        misalign_err;
    logic        halted;
    logic [15:0] redirect_count;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    branch_redirect_pc dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .br_valid       (br_valid),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .pc             (pc),
        .pc_valid       (pc_valid),
        .flush          (flush),
        .redirect_ack   (redirect_ack),
        .misalign_err   (misalign_err),
        .halted         (halted),
        .redirect_count (redirect_count)
    );

    always #5 clk = ~clk;

    function automatic stim_t mk(input logic rst, input logic stl, input logic bv, input logic bt,
                                 input logic [7:0] tgt, input logic [7:0] epc, input logic ev,
                                 input logic ef, input logic ea, input logic ee, input logic eh,
                                 input logic [15:0] ec);
        stim_t s;
        s.rst = rst; s.stall = stl; s.bv = bv; s.bt = bt; s.tgt = tgt;
        s.e.pc = epc; s.e.pc_valid = ev; s.e.flush = ef; s.e.ack = ea;
        s.e.err = ee; s.e.halted = eh; s.e.cnt = ec;
        return s;
    endfunction

    function automatic exp_t sample();
        exp_t o;
        o.pc = pc; o.pc_valid = pc_valid; o.flush = flush; o.ack = redirect_ack;
        o.err = misalign_err; o.halted = halted; o.cnt = redirect_count;
        return o;
    endfunction

    task automatic drive(input stim_t s);
        reset     = s.rst;
        stall     = s.stall;
        br_valid  = s.bv;
        br_taken  = s.bt;
        br_target = s.tgt;
    endtask

    task automatic test_reset();
        stim_t t[$];
        exp_t  e, o;
        t.push_back(mk(1,0,0,0,8'h00, 8'h00,0,0,0,0,0,16'd0));
        t.push_back(mk(0,0,0,0,8'h00, 8'h00,1,0,0,0,0,16'd0));
        t.push_back(mk(0,0,0,0,8'h00, 8'h04,1,0,0,0,0,16'd0));
        t.push_back(mk(0,0,0,0,8'h00, 8'h08,1,0,0,0,0,16'd0));
        t.push_back(mk(0,0,0,0,8'h00, 8'h0C,1,0,0,0,0,16'd0));
        t.push_back(mk(0,0,0,0,8'h00, 8'h10,1,0,0,0,0,16'd0));
        foreach (t[i]) begin
            drive(t[i]);
            exp_q.push_back(t[i].e);
            @(posedge clk); #1;
            o = sample(); e = exp_q.pop_front(); total++;
            if (o !== e) begin
                bad++;
                $display("FAIL reset step %0d got pc=%h v=%b fl=%b ack=%b err=%b halt=%b cnt=%h want pc=%h v=%b fl=%b ack=%b err=%b halt=%b cnt=%h",
                         i, o.pc, o.pc_valid, o.flush, o.ack, o.err, o.halted, o.cnt,
                         e.pc, e.pc_valid, e.flush, e.ack, e.err, e.halted, e.cnt);
            end
        end
    endtask

    task automatic test_redirect();
        stim_t t[$];
        exp_t  e, o;
        t.push_back(mk(1,0,0,0,8'h00, 8'h00,0,0,0,0,0,16'd0));
        t.push_back(mk(0,0,0,0,8'h00, 8'h00,1,0,0,0,0,16'd0));
        t.push_back(mk(0,0,0,0,8'h00, 8'h04,1,0,0,0,0,16'd0));
        t.push_back(mk(0,0,0,0,8'h00, 8'h08,1,0,0,0,0,16'd0));
        t.push_back(mk(0,0,1,1,8'h40, 8'h40,1,1,1,0,0,16'd1));
        t.push_back(mk(0,0,0,0,8'h00, 8'h44,1,1,0,0,0,16'd1));
        t.push_back(mk(0,0,0,0,8'h00, 8'h48,1,0,0,0,0,16'd1));
        t.push_back(mk(0,0,0,0,8'h00, 8'h4C,1,0,0,0,0,16'd1));
        foreach (t[i]) begin
            drive(t[i]);
            exp_q.push_back(t[i].e);
            @(posedge clk); #1;
            o = sample(); e = exp_q.pop_front(); total++;
            if (o !== e) begin
                bad++;
                $display("FAIL redirect step %0d got pc=%h v=%b fl=%b ack=%b err=%b halt=%b cnt=%h want pc=%h v=%b fl=%b ack=%b err=%b halt=%b cnt=%h",
                         i, o.pc, o.pc_valid, o.flush, o.ack, o.err, o.halted, o.cnt,
                         e.pc, e.pc_valid, e.flush, e.ack, e.err, e.halted, e.cnt);
            end
        end
    endtask

    task automatic test_not_taken();
        stim_t t[$];
        exp_t  e, o;
        t.push_back(mk(0,0,1,0,8'h80, 8'h50,1,0,1,0,0,16'd1));
        t.push_back(mk(0,0,0,0,8'h00, 8'h54,1,0,0,0,0,16'd1));
        t.push_back(mk(0,1,1,0,8'h80, 8'h54,1,0,1,0,0,16'd1));
        foreach (t[i]) begin
            drive(t[i]);
            exp_q.push_back(t[i].e);
            @(posedge clk); #1;
            o = sample(); e = exp_q.pop_front(); total++;
            if (o !== e) begin
                bad++;
                $display("FAIL not_taken step %0d got pc=%h v=%b fl=%b ack=%b err=%b halt=%b cnt=%h want pc=%h v=%b fl=%b ack=%b err=%b halt=%b cnt=%h",
                         i, o.pc, o.pc_valid, o.flush, o.ack, o.err, o.halted, o.cnt,
                         e.pc, e.pc_valid, e.flush, e.ack, e.err, e.halted, e.cnt);
            end
        end
    endtask

    task automatic test_stall_redirect();
        stim_t t[$];
        exp_t  e, o;
        t.push_back(mk(0,1,1,1,8'h20, 8'h20,1,1,1,0,0,16'd2));
        t.push_back(mk(0,1,0,0,8'h00, 8'h20,1,1,0,0,0,16'd2));
        t.push_back(mk(0,1,0,0,8'h00, 8'h20,1,1,0,0,0,16'd2));
        t.push_back(mk(0,1,0,0,8'h00, 8'h20,1,1,0,0,0,16'd2));
        t.push_back(mk(0,0,0,0,8'h00, 8'h24,1,1,0,0,0,16'd2));
        t.push_back(mk(0,0,0,0,8'h00, 8'h28,1,0,0,0,0,16'd2));
        t.push_back(mk(0,0,0,0,8'h00, 8'h2C,1,0,0,0,0,16'd2));
        foreach (t[i]) begin
            drive(t[i]);
            exp_q.push_back(t[i].e);
            @(posedge clk); #1;
            o = sample(); e = exp_q.pop_front(); total++;
            if (o !== e) begin
                bad++;
                $display("FAIL stall_redirect step %0d got pc=%h v=%b fl=%b ack=%b err=%b halt=%b cnt=%h want pc=%h v=%b fl=%b ack=%b err=%b halt=%b cnt=%h",
                         i, o.pc, o.pc_valid, o.flush, o.ack, o.err, o.halted, o.cnt,
                         e.pc, e.pc_valid, e.flush, e.ack, e.err, e.halted, e.cnt);
            end
        end
    endtask

    task automatic test_misalign();
        stim_t t[$];
        exp_t  e, o;
        t.push_back(mk(0,0,1,1,8'h42, 8'h2C,0,1,1,1,1,16'd2));
        t.push_back(mk(0,0,1,1,8'h10, 8'h2C,0,1,0,1,1,16'd2));
        t.push_back(mk(0,0,0,0,8'h00, 8'h2C,0,1,0,1,1,16'd2));
        t.push_back(mk(1,0,0,0,8'h00, 8'h00,0,0,0,0,0,16'd0));
        t.push_back(mk(0,0,0,0,8'h00, 8'h00,1,0,0,0,0,16'd0));
        t.push_back(mk(0,0,0,0,8'h00, 8'h04,1,0,0,0,0,16'd0));
        foreach (t[i]) begin
            drive(t[i]);
            exp_q.push_back(t[i].e);
            @(posedge clk); #1;
            o = sample(); e = exp_q.pop_front(); total++;
            if (o !== e) begin
                bad++;
                $display("FAIL misalign step %0d got pc=%h v=%b fl=%b ack=%b err=%b halt=%b cnt=%h want pc=%h v=%b fl=%b ack=%b err=%b halt=%b cnt=%h",
                         i, o.pc, o.pc_valid, o.flush, o.ack, o.err, o.halted, o.cnt,
                         e.pc, e.pc_valid, e.flush, e.ack, e.err, e.halted, e.cnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t t[$];
        exp_t  e, o;
        t.push_back(mk(0,0,1,1,8'hF8, 8'hF8,1,1,1,0,0,16'd1));
        t.push_back(mk(0,0,0,0,8'h00, 8'hFC,1,1,0,0,0,16'd1));
        t.push_back(mk(0,0,0,0,8'h00, 8'h00,1,0,0,0,0,16'd1));
        t.push_back(mk(0,0,0,0,8'h00, 8'h04,1,0,0,0,0,16'd1));
        t.push_back(mk(0,0,1,1,8'h30, 8'h30,1,1,1,0,0,16'd2));
        t.push_back(mk(0,0,1,1,8'h10, 8'h10,1,1,1,0,0,16'd3));
        t.push_back(mk(0,0,0,0,8'h00, 8'h14,1,1,0,0,0,16'd3));
        t.push_back(mk(0,0,0,0,8'h00, 8'h18,1,0,0,0,0,16'd3));
        t.push_back(mk(0,0,1,1,8'h60, 8'h60,1,1,1,0,0,16'd4));
        t.push_back(mk(1,0,1,1,8'h80, 8'h00,0,0,0,0,0,16'd0));
        t.push_back(mk(0,0,0,0,8'h00, 8'h00,1,0,0,0,0,16'd0));
        foreach (t[i]) begin
            drive(t[i]);
            exp_q.push_back(t[i].e);
            @(posedge clk); #1;
            o = sample(); e = exp_q.pop_front(); total++;
            if (o !== e) begin
                bad++;
                $display("FAIL back_to_back step %0d got pc=%h v=%b fl=%b ack=%b err=%b halt=%b cnt=%h want pc=%h v=%b fl=%b ack=%b err=%b halt=%b cnt=%h",
                         i, o.pc, o.pc_valid, o.flush, o.ack, o.err, o.halted, o.cnt,
                         e.pc, e.pc_valid, e.flush, e.ack, e.err, e.halted, e.cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_redirect();
        test_not_taken();
        test_stall_redirect();
        test_misalign();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_redirect_pc.md
Name: branch_redirect_pc

Overview:
Fetch-side program counter unit that consumes the resolved branch target produced by the execute-stage target adder, where target = PC + (imm << 1) truncated to 8 bits. Normally it advances the 8-bit PC sequentially. On a taken branch it redirects the PC to the target and flushes the wrong-path instructions in IF/ID and ID/EX. On a misaligned target it halts fetch. It sits between the execute stage and instruction memory.

Parameters:
PC_W, 8, PC width; matches the 8-bit branch target bus
RESET_PC, 8'h00, PC value loaded on reset
PC_STEP, 4, sequential increment per fetch
FLUSH_CYCLES, 2, number of cycles flush is held after a redirect (1..7)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  hazard stall; hold PC when high
br_valid  input  1  execute stage has a resolved branch this cycle
br_taken  input  1  branch condition true (zero_flag AND branch); sampled only with br_valid
br_target  input  PC_W  branch target from execute-stage adder
pc  output  PC_W  current fetch address
pc_valid  output  1  pc is a legitimate fetch address
flush  output  1  squash IF/ID and ID/EX contents
redirect_ack  output  1  one-cycle pulse: a br_valid was consumed
misalign_err  output  1  sticky: taken target with br_target[1:0] != 0
halted  output  1  unit is in HALT state
redirect_count  output  16  number of taken redirects, saturating

Behaviour:
- Reset: all state updates on the clk edge with reset high.
  - pc=RESET_PC, pc_valid=0, flush=0, redirect_ack=0, misalign_err=0, halted=0, redirect_count=0.
  - State=RUN, flush counter=0.
  - pc_valid rises on the first edge after reset is released. pc does not advance on that edge.
- States: RUN, FLUSH, HALT.
- Sequential step, in RUN or FLUSH with stall=0 and no accepted redirect:
  - pc <= (pc + PC_STEP) mod 2^PC_W. Wrap 8'hFC -> 8'h00 is legal and raises no error.
- stall=1 with no redirect: pc holds and the flush counter holds.
- Taken redirect (br_valid & br_taken & br_target[1:0]==0), in RUN or FLUSH:
  - Takes priority over stall.
  - Next edge: pc <= br_target, state <= FLUSH, flush counter <= FLUSH_CYCLES.
  - redirect_count increments and saturates at 16'hFFFF.
- FLUSH state:
  - flush=1 while the counter is non-zero.
  - The counter decrements on each edge with stall=0.
  - When the counter reaches 0, state <= RUN and flush drops on that same edge.
  - pc advances sequentially from the target as in RUN.
- A new taken redirect during FLUSH reloads the counter and the PC. Back-to-back redirects are legal.
- Not-taken (br_valid & !br_taken): no PC change and no flush.
- Misaligned taken target (br_target[1:0] != 0):
  - Next edge: state <= HALT; misalign_err=1, halted=1, pc_valid=0, flush=1.
  - pc holds its old value.
  - redirect_count does not increment.
- HALT: all inputs are ignored; only reset exits.
- redirect_ack: registered, high for exactly one cycle after any edge where br_valid=1 and state != HALT. This covers taken, not-taken and misaligned branches.
- br_valid=0: br_taken and br_target are don't-care.
- Reset mid-FLUSH or in HALT: reset values apply at that edge.

Test Plan:
- Reset, then 4 free-running cycles with stall=0 -> pc sequence 00,04,08,0C,10; pc_valid=1, flush=0, redirect_ack=0.
- At pc=08, drive br_valid=1, br_taken=1, br_target=8'h40 for one cycle -> next cycle pc=40, flush=1 for exactly 2 cycles, then pc=48 with flush=0; redirect_ack pulses once; redirect_count=1.
- br_valid=1, br_taken=0, br_target=8'h80 -> pc continues sequentially, flush stays 0, redirect_ack pulses once, redirect_count unchanged.
- stall=1 together with a taken branch to 8'h20 -> pc=20 next cycle (redirect wins). Hold stall=1 for 3 cycles -> flush stays 1 and pc stays 20. Release stall -> 2 flush cycles complete, then pc=28.
- Taken branch to 8'h42 -> misalign_err=1, halted=1, pc_valid=0, pc frozen; a later taken branch to 8'h10 is ignored with no ack; assert reset -> pc=00, all flags clear.
- Start at pc=F8 with no branches -> pc F8,FC,00,04 (wrap, no error). Then issue a taken branch to 8'h10 during FLUSH from a prior redirect to 8'h30 -> pc=10, flush counter reloads to 2, redirect_count=2.
